// File: rtl/fpu_cnv_result_queue.sv
// In-order result queue for the FP conversion / sign-injection unit.
// NaN-boxes single-precision FP results on entry and keeps a sticky fflags accumulator for fcsr.
module fpu_cnv_result_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROB_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [63:0]             in_result,
  input  logic                    in_invalid,
  input  logic                    in_overflow,
  input  logic                    in_underflow,
  input  logic                    in_inexact,
  input  logic                    in_is_double,
  input  logic                    in_rd_is_fp,
  input  logic [4:0]              in_rd,
  input  logic [ROB_W-1:0]        in_rob_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_result,
  output logic [4:0]              out_fflags,
  output logic [4:0]              out_rd,
  output logic                    out_rd_is_fp,
  output logic [ROB_W-1:0]        out_rob_tag,
  output logic [4:0]              acc_fflags,
  input  logic                    fflags_clr,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [63:0]      result;
    logic [4:0]       fflags;
    logic [4:0]       rd;
    logic             rd_is_fp;
    logic [ROB_W-1:0] rob_tag;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [4:0]         r_acc;

  entry_t             w_in_entry;
  entry_t             w_head;
  logic               w_push;
  logic               w_pop;
  logic [4:0]         w_acc_nxt;

  assign in_ready  = (r_count < CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Build the stored entry; single-precision FP destinations get the upper word forced to ones.
  always_comb begin
    w_in_entry          = '0;
    w_in_entry.result   = in_result;
    if (in_rd_is_fp && !in_is_double) begin
      w_in_entry.result = {32'hFFFF_FFFF, in_result[31:0]};
    end
    w_in_entry.fflags   = {in_invalid, 1'b0, in_overflow, in_underflow, in_inexact};
    w_in_entry.rd       = in_rd;
    w_in_entry.rd_is_fp = in_rd_is_fp;
    w_in_entry.rob_tag  = in_rob_tag;
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign out_result   = w_head.result;
  assign out_fflags   = w_head.fflags;
  assign out_rd       = w_head.rd;
  assign out_rd_is_fp = w_head.rd_is_fp;
  assign out_rob_tag  = w_head.rob_tag;
  assign count        = r_count;
  assign acc_fflags   = r_acc;

  // Entry storage carries no reset; out_valid qualifies the head fields.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear wins over the old value, but a popped entry accepted in the same cycle still lands.
  always_comb begin
    w_acc_nxt = r_acc;
    if (fflags_clr) begin
      w_acc_nxt = '0;
    end
    if (w_pop) begin
      w_acc_nxt = w_acc_nxt | w_head.fflags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_nxt;
    end
  end

endmodule
